gauss_window_gen: RTL
=====================

GAUSS_WINDOW_GEN -- requirements
Module: gauss_window_gen

Interface
REQ-001 Parameter DATA_W, default 8, pixel width in bits.
REQ-002 Parameter IMG_W, default 64, pixels per line (>= 3).
REQ-003 Parameter IMG_H, default 64, lines per frame (>= 3).
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 in_valid  input  1  in_pixel valid this cycle; no backpressure.
REQ-007 in_sof  input  1  start of frame; qualified by in_valid; marks the pixel at row 0, col 0.
REQ-008 in_pixel  input  DATA_W  raster-order pixel.
REQ-009 out_valid  output  1  win holds a complete 3x3 window this cycle.
REQ-010 win  output  9*DATA_W  window to the downstream multiplier/5:3 compressor tree; packed w00..w22 from MSB to LSB, row-major; w00 = oldest line, oldest column; w22 = newest pixel.
REQ-011 out_eof  output  1  one-cycle pulse, registered with the last pixel of a frame.

Function
REQ-012 Block shall keep a column counter col (0..IMG_W-1) and a row counter row (0..IMG_H-1), advanced only on in_valid=1.
REQ-013 col shall wrap IMG_W-1 -> 0 and increment row; row shall wrap IMG_H-1 -> 0 at the last pixel of a frame.
REQ-014 in_valid=1 with in_sof=1 shall treat the pixel as row 0, col 0 regardless of counter state; the counters then advance to row 0, col 1 (mid-frame resync).
REQ-015 Two line buffers (depth IMG_W, width DATA_W) shall hold the previous two lines; at address col, read shall precede write in the same cycle (read-before-write).
REQ-016 On each accepted pixel: line buffer 1 shall move to line buffer 0 at col, and in_pixel shall be written to line buffer 1 at col.
REQ-017 The 3x3 window register shall shift left one column per accepted pixel, loading {lb0[col], lb1[col], in_pixel} into column 2.
REQ-018 out_valid shall be 1 exactly one cycle after an accepted pixel with row >= 2 and col >= 2; otherwise 0 (valid-region only, no border padding).
REQ-019 Latency: in_pixel accepted at cycle t shall appear as w22 with out_valid at cycle t+1.
REQ-020 in_valid=0 cycles shall hold counters, buffers and win unchanged and drive out_valid=0 and out_eof=0.
REQ-021 out_eof shall be 1 one cycle after accepting pixel row IMG_H-1, col IMG_W-1, together with that pixel's out_valid.
REQ-022 Per frame out_valid count shall be (IMG_W-2)*(IMG_H-2).
REQ-023 Line buffer contents are not reset; REQ-018 gating shall guarantee no stale data reaches win with out_valid=1 after reset or resync.

Reset
REQ-024 rst_n=0 shall immediately force out_valid=0, out_eof=0, win=0, col=0, row=0.
REQ-025 Reset deassertion shall be synchronised internally; the first accepted pixel after reset is row 0, col 0 without requiring in_sof.
REQ-026 Reset mid-frame shall discard the partial frame; no out_valid until row>=2, col>=2 of the new frame.

Verification
REQ-027 IMG_W=4, IMG_H=4, pixels 0..15 back-to-back, in_sof on pixel 0 -> first out_valid one cycle after pixel 10, win = 0,1,2,4,5,6,8,9,10.
REQ-028 Same frame -> exactly 4 out_valid pulses with centres 5,6,9,10; out_eof with the last, win = 5,6,7,9,10,11,13,14,15.
REQ-029 Same frame with in_valid=0 between every pixel -> identical window sequence, out_valid never on two consecutive cycles.
REQ-030 Two frames back-to-back, second frame pixels 100..115 -> first window of frame 2 = 100,101,102,104,105,106,108,109,110; no out_valid at frame-2 rows 0-1.
REQ-031 in_sof asserted at frame-1 pixel 6, then pixels 50.. -> counters restart; first out_valid after the 11th pixel from resync, window built only from pixels 50..60.
REQ-032 rst_n pulsed low after pixel 9 -> out_valid, out_eof, win zero asynchronously; restart with pixels 0..15 reproduces REQ-027 results.

Source files
------------

// File: rtl/gauss_window_gen.sv
// gauss_window_gen: 3x3 sliding-window generator for a raster pixel stream.
//
// Two line buffers hold the previous two image lines; each accepted pixel shifts a
// 3x3 window register left by one column and loads {line-2, line-1, new pixel} into
// its right-hand column. A window is flagged valid only when it lies entirely inside
// the frame (row >= 2 and col >= 2), so there is no border padding.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset (deassertion synchronised internally)
//   in_valid   pixel strobe, no backpressure
//   in_sof     start of frame, qualified by in_valid; forces row 0, col 0
//   in_pixel   raster-order pixel
//   out_valid  win holds a complete in-frame 3x3 window
//   win        w00..w22 packed MSB to LSB, row-major; w00 oldest, w22 newest
//   out_eof    pulse coincident with the window of the last pixel of a frame

module gauss_window_gen #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned IMG_W  = 64,
  parameter int unsigned IMG_H  = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic                  in_sof,
  input  logic [DATA_W-1:0]     in_pixel,
  output logic                  out_valid,
  output logic [9*DATA_W-1:0]   win,
  output logic                  out_eof
);

  localparam int unsigned ColW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int unsigned RowW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

  localparam logic [ColW-1:0] ColLast = ColW'(IMG_W - 1);
  localparam logic [RowW-1:0] RowLast = RowW'(IMG_H - 1);
  localparam logic [ColW-1:0] ColFirstValid = ColW'(2);
  localparam logic [RowW-1:0] RowFirstValid = RowW'(2);

  // ---------------------------------------------------------------------------
  // Reset synchroniser: assertion is immediate, release waits two clock edges so
  // the first accepted pixel never races the reset edge.
  // ---------------------------------------------------------------------------
  logic [1:0] rst_sync_q;
  logic       run;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_sync_q <= 2'b00;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
  end

  assign run = rst_sync_q[1];

  logic accept;
  assign accept = in_valid & run;

  // ---------------------------------------------------------------------------
  // Position counters. in_sof overrides the stored position so a resync pixel is
  // processed as (0,0) in the same cycle it arrives.
  // ---------------------------------------------------------------------------
  logic [ColW-1:0] col_q, col_d, col_cur;
  logic [RowW-1:0] row_q, row_d, row_cur;

  assign col_cur = in_sof ? '0 : col_q;
  assign row_cur = in_sof ? '0 : row_q;

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (accept) begin
      if (col_cur == ColLast) begin
        col_d = '0;
        row_d = (row_cur == RowLast) ? '0 : row_cur + 1'b1;
      end else begin
        col_d = col_cur + 1'b1;
        row_d = row_cur;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Line buffers. lb0 holds line row-2, lb1 holds line row-1 at each column.
  // Reads are combinational from the current contents, so a same-cycle write at
  // the same address is seen only on the next access (read-before-write).
  // Contents are deliberately not reset; the valid gating keeps stale data out.
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] lb0_mem [IMG_W];
  logic [DATA_W-1:0] lb1_mem [IMG_W];
  logic [DATA_W-1:0] lb0_rd, lb1_rd;

  assign lb0_rd = lb0_mem[col_cur];
  assign lb1_rd = lb1_mem[col_cur];

  always_ff @(posedge clk) begin
    if (accept) begin
      lb0_mem[col_cur] <= lb1_rd;
      lb1_mem[col_cur] <= in_pixel;
    end
  end

  // ---------------------------------------------------------------------------
  // Window register, indexed [row][col]; row 0 is the oldest line, col 2 the
  // newest column.
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] win_q [3][3];
  logic [DATA_W-1:0] win_d [3][3];

  always_comb begin
    win_d = win_q;
    if (accept) begin
      for (int r = 0; r < 3; r++) begin
        win_d[r][0] = win_q[r][1];
        win_d[r][1] = win_q[r][2];
      end
      win_d[0][2] = lb0_rd;
      win_d[1][2] = lb1_rd;
      win_d[2][2] = in_pixel;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_q <= '{default: '0};
    end else begin
      win_q <= win_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Output flags: one-cycle pulses tied to the pixel accepted on the previous edge.
  // ---------------------------------------------------------------------------
  logic valid_q, valid_d;
  logic eof_q, eof_d;

  always_comb begin
    valid_d = accept && (row_cur >= RowFirstValid) && (col_cur >= ColFirstValid);
    eof_d   = accept && (row_cur == RowLast) && (col_cur == ColLast);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      eof_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      eof_q   <= eof_d;
    end
  end

  assign out_valid = valid_q;
  assign out_eof   = eof_q;

  // Pack w00 at the MSB down to w22 at the LSB.
  always_comb begin
    win = '0;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        win[(8 - (3 * r + c)) * DATA_W +: DATA_W] = win_q[r][c];
      end
    end
  end

endmodule
